// File: rtl/nios_system_pio_in_edge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_system_pio_in_edge_if                                 |
// | Description : Avalon-MM slave bus bundle for the edge-capturing input    |
// |               PIO. Groups the register select, write strobe/data and     |
// |               registered read data.                                      |
// |   address    [1:0]   register select                                     |
// |   chipselect         slave select                                        |
// |   write_n            active-low write strobe                             |
// |   writedata  [31:0]  write data                                          |
// |   readdata   [31:0]  registered read data (driven by the slave)          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface nios_system_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/nios_system_pio_in_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nios_system_pio_in_edge                                    |
// | Description : Parametrised Avalon-MM input PIO with input synchroniser,  |
// |               per-bit edge capture (write-1-to-clear), per-bit IRQ mask  |
// |               and a registered level IRQ.                                |
// |   clk        system clock, rising edge                                   |
// |   reset_n    synchronous active-low reset                                |
// |   bus        Avalon-MM slave (address/chipselect/write_n/writedata/      |
// |              readdata)                                                   |
// |   in_port    [WIDTH-1:0] asynchronous external inputs                    |
// |   irq        level interrupt, active high                                |
// | Register map: 0 data (RO), 1 irq_mask (RW), 2 reserved, 3 edge (W1C)     |
// | Optional    : define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce     |
// |               filter of DEBOUNCE_CYCLES between synchroniser and logic.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module nios_system_pio_in_edge #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nios_system_pio_in_edge_if.slave      bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync_val;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_irq_mask;
  logic [31:0]      r_readdata;
  logic             r_irq;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync_val = r_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------ debounce
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int c_db_w        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_arm_cycles  = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

  logic [c_db_w-1:0] r_db_cnt [WIDTH];
  logic [WIDTH-1:0]  r_filt;

  // Counter tracks how long sync has disagreed with the filtered value; the
  // filtered bit flips on the DEBOUNCE_CYCLES-th consecutive disagreement.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_filt <= '0;
      for (int b = 0; b < WIDTH; b++) r_db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (w_sync_val[b] == r_filt[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[b]   <= w_sync_val[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_data = r_filt;
`else
  localparam int c_arm_cycles      = SYNC_STAGES + 1;
  localparam int c_unused_debounce = DEBOUNCE_CYCLES;

  assign w_data = w_sync_val;
`endif

  // ------------------------------------------------------------- arming
  // Edge detection stays off until the pipeline has been refilled from
  // reset, so inputs already high at reset release are not captured.
  localparam int c_arm_w = $clog2(c_arm_cycles + 1);

  logic [c_arm_w-1:0] r_arm_cnt;
  logic               w_armed;

  assign w_armed = (r_arm_cnt == c_arm_w'(c_arm_cycles));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------- edge detect
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;

  if (EDGE_TYPE == 0) begin : g_rise
    assign w_edge_raw = w_data & ~r_prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign w_edge_raw = ~w_data & r_prev;
  end else begin : g_any
    assign w_edge_raw = w_data ^ r_prev;
  end

  assign w_edge = w_armed ? w_edge_raw : '0;

  // ------------------------------------------------------------ bus side
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_ec_next;
  logic [WIDTH-1:0] w_mask_next;
  logic [31:0]      w_rd_mux;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wdata = bus.writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wdata_hi
    logic w_unused_wdata_hi;
    assign w_unused_wdata_hi = |bus.writedata[31:WIDTH];
  end

  assign w_w1c       = (w_wr && bus.address == 2'd3) ? w_wdata : '0;
  // Set is OR-ed in after the clear, so a new edge wins over a same-cycle W1C.
  assign w_ec_next   = (r_edge_capture & ~w_w1c) | w_edge;
  assign w_mask_next = (w_wr && bus.address == 2'd1) ? w_wdata : r_irq_mask;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      2'd0:    w_rd_mux = 32'(w_data);
      2'd1:    w_rd_mux = 32'(r_irq_mask);
      2'd3:    w_rd_mux = 32'(r_edge_capture);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev         <= '0;
      r_edge_capture <= '0;
      r_irq_mask     <= '0;
      r_readdata     <= '0;
      r_irq          <= 1'b0;
    end else begin
      r_prev         <= w_data;
      r_edge_capture <= w_ec_next;
      r_irq_mask     <= w_mask_next;
      r_readdata     <= w_rd_mux;
      r_irq          <= |(w_ec_next & w_mask_next);
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_pio_in_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_nios_system_pio_in_edge                                 |
// | Description : Self-checking bench. Two instances (rising / any edge)     |
// |               share stimulus; a delay-line reference model checks every  |
// |               cycle, plus a directed vector table and corner sequences.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_nios_system_pio_in_edge;
  localparam int W  = 10;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int ARM = S + DB + 1;
`else
  localparam int ARM = S + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq0, irq2;
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           chk_en  = 1'b0;

  nios_system_pio_in_edge_if bus0 ();
  nios_system_pio_in_edge_if bus2 ();

  nios_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
  nios_system_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
  endtask

  // ------------------------------------------------------- reference model
  // Synchroniser modelled as a queue of the last S samples; the visible
  // value is the oldest one. Index 0 = rising-edge instance, 1 = any-edge.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_sync, m_data, m_prev, m_mask;
  logic [W-1:0] m_ec [2];
  logic [31:0]  m_rd [2];
  logic         m_irq[2];
  int           m_age;
  int           m_run[W];
  logic         m_wr;
  logic [W-1:0] m_clr, m_mask_n, m_ec_n, m_edge, m_sync_new;

  function automatic logic [W-1:0] det(input int e, input logic [W-1:0] cur, input logic [W-1:0] prv);
    if (e == 0) return cur & ~prv;
    return cur ^ prv;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q.delete();
      m_sync = '0; m_data = '0; m_prev = '0; m_mask = '0; m_age = 0;
      for (int b = 0; b < W; b++) m_run[b] = 0;
      for (int e = 0; e < 2; e++) begin m_ec[e] = '0; m_rd[e] = '0; m_irq[e] = 1'b0; end
    end else begin
      m_wr     = bus0.chipselect && !bus0.write_n;
      m_clr    = (m_wr && bus0.address == 2'd3) ? bus0.writedata[W-1:0] : '0;
      m_mask_n = (m_wr && bus0.address == 2'd1) ? bus0.writedata[W-1:0] : m_mask;
      for (int e = 0; e < 2; e++) begin
        m_edge = (m_age >= ARM) ? det(e, m_data, m_prev) : '0;
        m_ec_n = (m_ec[e] & ~m_clr) | m_edge;
        case (bus0.address)
          2'd0:    m_rd[e] = {22'd0, m_data};
          2'd1:    m_rd[e] = {22'd0, m_mask};
          2'd3:    m_rd[e] = {22'd0, m_ec[e]};
          default: m_rd[e] = 32'd0;
        endcase
        m_irq[e] = |(m_ec_n & m_mask_n);
        m_ec[e]  = m_ec_n;
      end
      m_mask = m_mask_n;
      m_prev = m_data;
      m_q.push_back(in_port);
      if (m_q.size() > S) void'(m_q.pop_front());
      m_sync_new = (m_q.size() == S) ? m_q[0] : '0;
`ifdef PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
        if (m_sync[b] !== m_data[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin m_data[b] = m_sync[b]; m_run[b] = 0; end
        end else begin
          m_run[b] = 0;
        end
      end
`else
      m_data = m_sync_new;
`endif
      m_sync = m_sync_new;
      if (m_age < 1000) m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd_rise", bus0.readdata, m_rd[0]);
      check("model_irq_rise", {31'd0, irq0}, {31'd0, m_irq[0]});
      check("model_rd_any", bus2.readdata, m_rd[1]);
      check("model_irq_any", {31'd0, irq2}, {31'd0, m_irq[1]});
    end
  end

  // ------------------------------------------------------- directed table
  typedef struct {
    logic [1:0]   addr;
    logic         wr;
    logic [31:0]  wd;
    logic [W-1:0] din;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t tbl[27];

  initial begin
    // Each record is applied before one edge; expectations are for the
    // rising-edge instance just after that edge. First record = reset release.
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        10'h3FF, 32'h000, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 32'h0,        10'h3FF, 32'h000, 1'b0};
    tbl[2]  = '{2'd0, 1'b0, 32'h0,        10'h3FF, 32'h3FF, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0,        10'h3FF, 32'h000, 1'b0};
    tbl[4]  = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[5]  = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[6]  = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[7]  = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[8]  = '{2'd0, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[9]  = '{2'd3, 1'b0, 32'h0,        10'h008, 32'h000, 1'b0};
    tbl[10] = '{2'd3, 1'b0, 32'h0,        10'h008, 32'h000, 1'b0};
    tbl[11] = '{2'd3, 1'b0, 32'h0,        10'h008, 32'h000, 1'b0};
    tbl[12] = '{2'd3, 1'b0, 32'h0,        10'h008, 32'h008, 1'b0};
    tbl[13] = '{2'd1, 1'b1, 32'h008,      10'h008, 32'h000, 1'b1};
    tbl[14] = '{2'd1, 1'b0, 32'h0,        10'h008, 32'h008, 1'b1};
    tbl[15] = '{2'd3, 1'b1, 32'h004,      10'h008, 32'h008, 1'b1};
    tbl[16] = '{2'd3, 1'b1, 32'h008,      10'h008, 32'h008, 1'b0};
    tbl[17] = '{2'd3, 1'b0, 32'h0,        10'h008, 32'h000, 1'b0};
    tbl[18] = '{2'd0, 1'b0, 32'h0,        10'h008, 32'h008, 1'b0};
    tbl[19] = '{2'd2, 1'b1, 32'hFFFFFFFF, 10'h008, 32'h000, 1'b0};
    tbl[20] = '{2'd1, 1'b0, 32'h0,        10'h008, 32'h008, 1'b0};
    tbl[21] = '{2'd3, 1'b0, 32'h0,        10'h028, 32'h000, 1'b0};
    tbl[22] = '{2'd3, 1'b0, 32'h0,        10'h028, 32'h000, 1'b0};
    tbl[23] = '{2'd3, 1'b1, 32'h020,      10'h028, 32'h000, 1'b0};
    tbl[24] = '{2'd3, 1'b0, 32'h0,        10'h028, 32'h020, 1'b0};
    tbl[25] = '{2'd1, 1'b1, 32'hFFFFFC20, 10'h028, 32'h008, 1'b1};
    tbl[26] = '{2'd1, 1'b0, 32'h0,        10'h028, 32'h020, 1'b1};
  end

  // ------------------------------------------------------------- sequence
  initial begin
    drive(2'd0, 1'b1, 1'b1, 32'h0);
    reset_n = 1'b0;
    in_port = 10'h3FF;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_rd", bus0.readdata, 32'h0);
    check("reset_irq", {31'd0, irq0}, 32'h0);
    reset_n = 1'b1;

`ifndef PIO_IN_DEBOUNCE_EN
    for (int k = 0; k < 27; k++) begin
      drive(tbl[k].addr, 1'b1, !tbl[k].wr, tbl[k].wd);
      in_port = tbl[k].din;
      @(negedge clk);
      check($sformatf("vec%0d_rd", k), bus0.readdata, tbl[k].exp_rd);
      check($sformatf("vec%0d_irq", k), {31'd0, irq0}, {31'd0, tbl[k].exp_irq});
    end

    // Reset in the middle of a write: everything returns to reset values.
    drive(2'd1, 1'b1, 1'b0, 32'h3FF);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_rd", bus0.readdata, 32'h0);
    check("midrst_irq", {31'd0, irq0}, 32'h0);
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (ARM + 3) @(negedge clk);
    check("rearm_ec", bus0.readdata, 32'h0);
    check("rearm_ec_any", bus2.readdata, 32'h0);
    drive(2'd0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("rearm_data", bus0.readdata, 32'h028);

    // Any-edge pulse on bit0, 10 cycles wide, cleared in between.
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    in_port = 10'h029;
    repeat (5) @(negedge clk);
    check("pulse_rise_any", bus2.readdata, 32'h001);
    check("pulse_rise_rise", bus0.readdata, 32'h001);
    drive(2'd3, 1'b1, 1'b0, 32'h001);
    @(negedge clk);
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    repeat (4) @(negedge clk);
    check("pulse_clr_any", bus2.readdata, 32'h000);
    in_port = 10'h028;
    repeat (4) @(negedge clk);
    check("pulse_fall_any", bus2.readdata, 32'h001);
    check("pulse_fall_rise", bus0.readdata, 32'h000);
`else
    drive(2'd0, 1'b1, 1'b1, 32'h0);
    repeat (ARM + 2) @(negedge clk);
    check("hold_data", bus0.readdata, 32'h3FF);
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("hold_ec", bus0.readdata, 32'h0);
    check("hold_irq", {31'd0, irq0}, 32'h0);
    in_port = '0;
    repeat (15) @(negedge clk);
    drive(2'd3, 1'b1, 1'b0, 32'h3FF);
    @(negedge clk);
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    in_port = 10'h002;
    repeat (3) @(negedge clk);
    in_port = '0;
    repeat (10) @(negedge clk);
    check("glitch_ec", bus0.readdata, 32'h0);
    check("glitch_ec_any", bus2.readdata, 32'h0);
    drive(2'd0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("glitch_data", bus0.readdata, 32'h0);
    in_port = 10'h002;
    repeat (6) @(negedge clk);
    in_port = '0;
    @(negedge clk);
    check("db_data", bus0.readdata, 32'h002);
    drive(2'd3, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("db_ec", bus0.readdata, 32'h002);
`endif

    // Randomised traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_port = in_port ^ (W'($urandom) & W'($urandom) & W'($urandom));
      drive(2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
